// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch, miss and halt
// requests into per-stage enables/flushes and arbitrates the shared memory fill port.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned FILL_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic ld_use_stall,
    input  logic branch_taken,
    input  logic halt_id,
    input  logic imiss,
    input  logic dmiss,
    input  logic mem_done,
    output logic pc_en,
    output logic if_id_en,
    output logic id_ex_en,
    output logic ex_mem_en,
    output logic mem_wb_en,
    output logic if_id_flush,
    output logic id_ex_flush,
    output logic mem_req,
    output logic mem_sel,
    output logic halted,
    output logic fill_err
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned FW = $clog2(FILL_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [FW-1:0] FILL_MAX   = FW'(FILL_TIMEOUT - 1);

    typedef enum logic [2:0] {StRun, StFillD, StFillI, StDrain, StHalt} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic          ret_q, ret_d;
    logic          fill_err_q, fill_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            fill_cnt_q  <= '0;
            ret_q       <= 1'b0;
            fill_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            ret_q       <= ret_d;
            fill_err_q  <= fill_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        ret_d       = ret_q;
        fill_err_d  = fill_err_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        halted      = 1'b0;

        // Outputs are forced quiet for the whole time rst is held, not just after the edge.
        if (!rst) begin
            case (state_q)
                StRun: begin
                    if (dmiss) begin
                        state_d = StFillD;
                        ret_d   = 1'b0;
                    end else if (imiss) begin
                        state_d = StFillI;
                        ret_d   = 1'b0;
                    end else if (ld_use_stall) begin
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (halt_id) begin
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                        drain_cnt_d = DRAIN_LOAD;
                        state_d     = StDrain;
                    end else begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = branch_taken;
                    end
                end
                StFillD, StFillI: begin
                    mem_req = 1'b1;
                    mem_sel = (state_q == StFillD);
                    if (mem_done) begin
                        fill_cnt_d = '0;
                        // Chain straight into the I-fill so mem_req never drops between fills.
                        if (state_q == StFillD && imiss) begin
                            state_d = StFillI;
                        end else begin
                            state_d = ret_q ? StDrain : StRun;
                        end
                    end else if (fill_cnt_q == FILL_MAX) begin
                        fill_err_d = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FW'(1);
                    end
                end
                StDrain: begin
                    if (dmiss) begin
                        state_d = StFillD;
                        ret_d   = 1'b1;
                    end else begin
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                        if (drain_cnt_q <= DW'(1)) begin
                            drain_cnt_d = '0;
                            state_d     = StHalt;
                        end else begin
                            drain_cnt_d = drain_cnt_q - DW'(1);
                        end
                    end
                end
                StHalt: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    assign fill_err = fill_err_q;

endmodule
